// File: rtl/leds_pkg.sv
// Register map shared by the LED PWM block and anything that addresses it.
// Pure constants: no logic, no latency, no flow control.
package leds_pkg;
    localparam logic [3:0] ADDR_ENABLE       = 4'd0;
    localparam logic [3:0] ADDR_BLINK_MASK   = 4'd1;
    localparam logic [3:0] ADDR_BLINK_PERIOD = 4'd2;
    localparam logic [3:0] ADDR_STATUS       = 4'd3;
    localparam logic [3:0] ADDR_DUTY_BASE    = 4'd8;
endpackage

// File: rtl/leds_pwm_chan.sv
// One LED channel: duty compare, enable and blink gating into an output flop.
// Latency 1 cycle from counter value to LED; no backpressure.
module leds_pwm_chan
    import leds_pkg::*;
#(
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [PWM_BITS-1:0] i_cnt,
    input  logic [PWM_BITS-1:0] i_duty,
    input  logic                i_enable,
    input  logic                i_blink_mask,
    input  logic                i_blink_phase,
    output logic                o_led
);
    logic w_on;
    logic r_led;

    // All-ones duty must stay on through the counter's top value as well.
    assign w_on = i_enable
                  && ((i_duty == '1) || (i_cnt < i_duty))
                  && !(i_blink_mask && !i_blink_phase);

    always_ff @(posedge clk) begin
        if (reset) r_led <= 1'b0;
        else       r_led <= w_on;
    end

    assign o_led = r_led;
endmodule

// File: rtl/leds_pwm.sv
// Register-mapped multi-channel LED PWM with optional blink (LEDS_PWM_BLINK_EN).
// Read data 1 cycle after strobe, LEDs 1 cycle after counter; no backpressure.
module leds_pwm
    import leds_pkg::*;
#(
    parameter int NUM_LEDS = 8,
    parameter int PWM_BITS = 8
) (
    input  logic                clk,
    input  logic                reset,
    input  logic [3:0]          slave_address,
    input  logic                slave_write,
    input  logic [15:0]         slave_writedata,
    input  logic                slave_read,
    output logic [15:0]         slave_readdata,
    output logic [NUM_LEDS-1:0] user_dataout_0
);
    logic [PWM_BITS-1:0] r_cnt;
    logic [NUM_LEDS-1:0] r_enable;
    logic [PWM_BITS-1:0] r_duty_sh  [NUM_LEDS];
    logic [PWM_BITS-1:0] r_duty_act [NUM_LEDS];
    logic [15:0]         r_rdata;
    logic [15:0]         w_rdata;
    logic                w_wrap;
    logic [NUM_LEDS-1:0] w_duty_hit;
    logic [NUM_LEDS-1:0] w_blink_mask;
    logic [15:0]         w_blink_period;
    logic                w_blink_phase;
    logic [NUM_LEDS-1:0] w_led;

    assign w_wrap = (r_cnt == '1);

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_hit
        assign w_duty_hit[g] = (slave_address == ADDR_DUTY_BASE + 4'(g));
    end

    always_ff @(posedge clk) begin
        if (reset) begin
            r_cnt    <= '0;
            r_enable <= '0;
            r_rdata  <= '0;
            for (int i = 0; i < NUM_LEDS; i++) begin
                r_duty_sh[i]  <= '0;
                r_duty_act[i] <= '0;
            end
        end else begin
            r_cnt <= r_cnt + 1'b1;
            if (slave_write && slave_address == ADDR_ENABLE)
                r_enable <= slave_writedata[NUM_LEDS-1:0];
            // Active duty only moves at the wrap so a period is never split.
            for (int i = 0; i < NUM_LEDS; i++) begin
                if (slave_write && w_duty_hit[i])
                    r_duty_sh[i] <= slave_writedata[PWM_BITS-1:0];
                if (w_wrap)
                    r_duty_act[i] <= r_duty_sh[i];
            end
            if (slave_read)
                r_rdata <= w_rdata;
        end
    end

`ifdef LEDS_PWM_BLINK_EN
    logic [NUM_LEDS-1:0] r_blink_mask;
    logic [15:0]         r_blink_period;
    logic [15:0]         r_per_cnt;
    logic                r_blink_phase;

    always_ff @(posedge clk) begin
        if (reset) begin
            r_blink_mask   <= '0;
            r_blink_period <= '0;
            r_per_cnt      <= '0;
            r_blink_phase  <= 1'b1;
        end else begin
            if (slave_write && slave_address == ADDR_BLINK_MASK)
                r_blink_mask <= slave_writedata[NUM_LEDS-1:0];
            if (slave_write && slave_address == ADDR_BLINK_PERIOD)
                r_blink_period <= slave_writedata;
            // >= so a period shrunk below the running count still toggles next wrap.
            if (w_wrap) begin
                if (r_per_cnt >= r_blink_period) begin
                    r_per_cnt     <= '0;
                    r_blink_phase <= ~r_blink_phase;
                end else begin
                    r_per_cnt <= r_per_cnt + 1'b1;
                end
            end
        end
    end

    assign w_blink_mask   = r_blink_mask;
    assign w_blink_period = r_blink_period;
    assign w_blink_phase  = r_blink_phase;
`else
    assign w_blink_mask   = '0;
    assign w_blink_period = '0;
    assign w_blink_phase  = 1'b1;
`endif

    always_comb begin
        w_rdata = '0;
        case (slave_address)
            ADDR_ENABLE:       w_rdata = 16'(r_enable);
            ADDR_BLINK_MASK:   w_rdata = 16'(w_blink_mask);
            ADDR_BLINK_PERIOD: w_rdata = w_blink_period;
            ADDR_STATUS:       w_rdata = {15'd0, w_blink_phase};
            default: begin
                for (int i = 0; i < NUM_LEDS; i++)
                    if (w_duty_hit[i]) w_rdata = 16'(r_duty_sh[i]);
            end
        endcase
    end

    for (genvar g = 0; g < NUM_LEDS; g++) begin : g_chan
        leds_pwm_chan #(.PWM_BITS(PWM_BITS)) u_chan (
            .clk           (clk),
            .reset         (reset),
            .i_cnt         (r_cnt),
            .i_duty        (r_duty_act[g]),
            .i_enable      (r_enable[g]),
            .i_blink_mask  (w_blink_mask[g]),
            .i_blink_phase (w_blink_phase),
            .o_led         (w_led[g])
        );
    end

    assign user_dataout_0 = w_led;
    assign slave_readdata = r_rdata;
endmodule

// File: tb/tb_leds_pwm.sv
// Directed bench for leds_pwm (8 channels, 8-bit PWM); blink checks follow LEDS_PWM_BLINK_EN.
module tb_leds_pwm;
    localparam int NL = 8;
    localparam int PB = 8;
`ifdef LEDS_PWM_BLINK_EN
    localparam bit BLINK = 1'b1;
`else
    localparam bit BLINK = 1'b0;
`endif

    logic          clk = 1'b0;
    logic          reset = 1'b1;
    logic [3:0]    slave_address = '0;
    logic          slave_write = 1'b0;
    logic [15:0]   slave_writedata = '0;
    logic          slave_read = 1'b0;
    logic [15:0]   slave_readdata;
    logic [NL-1:0] user_dataout_0;

    leds_pwm #(.NUM_LEDS(NL), .PWM_BITS(PB)) dut (
        .clk             (clk),
        .reset           (reset),
        .slave_address   (slave_address),
        .slave_write     (slave_write),
        .slave_writedata (slave_writedata),
        .slave_read      (slave_read),
        .slave_readdata  (slave_readdata),
        .user_dataout_0  (user_dataout_0)
    );

    always #5 clk = ~clk;

    int checks = 0;
    int errors = 0;

    // Reference PWM counter and wrap count, kept from the bench's own clock view.
    logic [7:0] m_cnt = '0;
    int         m_wraps = 0;
    always @(posedge clk) begin
        if (reset) begin
            m_cnt   <= '0;
            m_wraps <= 0;
        end else begin
            m_cnt <= m_cnt + 8'd1;
            if (m_cnt == 8'hFF) m_wraps <= m_wraps + 1;
        end
    end

    typedef struct {
        logic [3:0]  addr;
        logic [15:0] wdata;
        logic [15:0] exp;
    } vec_t;
    vec_t tbl [11];

    task automatic chk(input string nm, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h", nm, act, exp);
        end
    endtask

    // Every bus task starts and ends on a falling edge.
    task automatic wr(input logic [3:0] a, input logic [15:0] d);
        slave_address = a; slave_writedata = d; slave_write = 1'b1;
        @(negedge clk);
        slave_write = 1'b0;
    endtask

    task automatic rd(input logic [3:0] a, output logic [15:0] d);
        slave_address = a; slave_read = 1'b1;
        @(negedge clk);
        slave_read = 1'b0;
        d = slave_readdata;
    endtask

    task automatic do_reset();
        reset = 1'b1;
        @(negedge clk);
        @(negedge clk);
        reset = 1'b0;
    endtask

    task automatic wait_cnt(input logic [7:0] v);
        int n = 0;
        while (m_cnt != v && n < 600) begin
            @(negedge clk);
            n++;
        end
        chk("wait_cnt", 32'(m_cnt), 32'(v));
    endtask

    initial begin
        #2_000_000;
        errors++;
        $display("FAIL watchdog timeout");
        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $fatal(1);
    end

    initial begin
        logic [15:0] d;
        int hi, bad, n;
        logic [NL-1:0] acc;
        logic expb;

        tbl[0]  = '{4'h0, 16'hFFA5, 16'h00A5};
        tbl[1]  = '{4'h1, 16'hFF3C, BLINK ? 16'h003C : 16'h0000};
        tbl[2]  = '{4'h2, 16'hBEEF, BLINK ? 16'hBEEF : 16'h0000};
        tbl[3]  = '{4'h4, 16'h1234, 16'h0000};
        tbl[4]  = '{4'h5, 16'hFFFF, 16'h0000};
        tbl[5]  = '{4'h6, 16'h00FF, 16'h0000};
        tbl[6]  = '{4'h7, 16'h5555, 16'h0000};
        tbl[7]  = '{4'h8, 16'hAB12, 16'h0012};
        tbl[8]  = '{4'hF, 16'hFFFF, 16'h00FF};
        tbl[9]  = '{4'hB, 16'h0180, 16'h0080};
        tbl[10] = '{4'h3, 16'hFFFF, 16'h0000};

        @(negedge clk);
        do_reset();

        // Reset state
        chk("rst_leds", 32'(user_dataout_0), 32'h0);
        chk("rst_rdata", 32'(slave_readdata), 32'h0);
        rd(4'h3, d); chk("rst_status", 32'(d), 32'h1);
        rd(4'h0, d); chk("rst_enable", 32'(d), 32'h0);
        rd(4'h1, d); chk("rst_mask", 32'(d), 32'h0);
        rd(4'h2, d); chk("rst_period", 32'(d), 32'h0);
        rd(4'h8, d); chk("rst_duty0", 32'(d), 32'h0);

        // Register write/readback table; STATUS row expects no visible write
        // (readback masked to the phase bit, which is not the point here).
        for (int i = 0; i < 11; i++) begin
            wr(tbl[i].addr, tbl[i].wdata);
            rd(tbl[i].addr, d);
            if (tbl[i].addr == 4'h3) d[0] = 1'b0;
            chk($sformatf("vec%0d_a%0h", i, tbl[i].addr), 32'(d), 32'(tbl[i].exp));
        end
        rd(4'h0, d); chk("enable_kept", 32'(d), 32'h00A5);

        // Same-cycle read and write of ENABLE returns the old value
        slave_address = 4'h0; slave_writedata = 16'h005A;
        slave_write = 1'b1; slave_read = 1'b1;
        @(negedge clk);
        slave_write = 1'b0; slave_read = 1'b0;
        chk("rw_same_old", 32'(slave_readdata), 32'h00A5);
        rd(4'h0, d); chk("rw_same_new", 32'(d), 32'h005A);

        // Channel 0 at duty 64
        do_reset();
        wr(4'h0, 16'h0001);
        wr(4'h8, 16'd64);
        repeat (300) @(negedge clk);
        hi = 0; acc = '0;
        repeat (256) begin
            hi += int'(user_dataout_0[0]);
            acc |= user_dataout_0 & 8'hFE;
            @(negedge clk);
        end
        chk("duty64_high", 32'(hi), 32'd64);
        chk("duty64_others", 32'(acc), 32'h0);

        // Rewrite to 192 at counter 100: current period keeps 64
        wait_cnt(8'd100);
        wr(4'h8, 16'd192);
        rd(4'h8, d); chk("duty192_readback", 32'(d), 32'd192);
        hi = 0; n = 0;
        do begin
            hi += int'(user_dataout_0[0]);
            @(negedge clk);
            n++;
        end while (m_cnt != 8'd1 && n < 300);
        chk("duty_rest_of_period", 32'(hi), 32'd0);
        hi = 0;
        repeat (256) begin
            hi += int'(user_dataout_0[0]);
            @(negedge clk);
        end
        chk("duty192_next_period", 32'(hi), 32'd192);

        // Duty 0, 255, and a mix across all channels
        do_reset();
        wr(4'h0, 16'h00FF);
        for (int i = 0; i < NL; i++) wr(4'(8 + i), 16'd0);
        repeat (300) @(negedge clk);
        acc = '0;
        repeat (256) begin acc |= user_dataout_0; @(negedge clk); end
        chk("duty0_off", 32'(acc), 32'h0);
        for (int i = 0; i < NL; i++) wr(4'(8 + i), 16'd255);
        repeat (300) @(negedge clk);
        acc = '1;
        repeat (256) begin acc &= user_dataout_0; @(negedge clk); end
        chk("duty255_on", 32'(acc), 32'hFF);
        for (int i = 0; i < NL; i++) wr(4'(8 + i), (i % 2 == 1) ? 16'd255 : 16'd0);
        repeat (300) @(negedge clk);
        bad = 0;
        repeat (256) begin bad += int'(user_dataout_0 != 8'hAA); @(negedge clk); end
        chk("duty_mix_aa", 32'(bad), 32'd0);

`ifdef LEDS_PWM_BLINK_EN
        // Blink every 2 PWM periods on channel 1; phase drops at the 2nd wrap
        do_reset();
        wr(4'h2, 16'd1);
        wr(4'h1, 16'h0002);
        wr(4'h0, 16'h0002);
        wr(4'h9, 16'd255);
        n = 0;
        while (!(m_wraps == 2 && m_cnt == 8'd1) && n < 1200) begin
            @(negedge clk);
            n++;
        end
        chk("blink_sync", 32'(m_wraps), 32'd2);
        for (int blk = 0; blk < 4; blk++) begin
            expb = (blk % 2 == 1);
            bad = 0;
            for (int k = 0; k < 512; k++) begin
                if (k == 256) begin slave_address = 4'h3; slave_read = 1'b1; end
                if (k == 257) begin
                    slave_read = 1'b0;
                    chk($sformatf("blink_status%0d", blk), 32'(slave_readdata), 32'(expb));
                end
                bad += int'(user_dataout_0[1] != expb);
                @(negedge clk);
            end
            chk($sformatf("blink_block%0d", blk), 32'(bad), 32'd0);
        end
`else
        // Without blink logic the mask has no effect and phase stays 1
        do_reset();
        wr(4'h1, 16'h0002);
        wr(4'h2, 16'd0);
        wr(4'h0, 16'h0002);
        wr(4'h9, 16'd255);
        repeat (300) @(negedge clk);
        bad = 0;
        repeat (1024) begin bad += int'(user_dataout_0 != 8'h02); @(negedge clk); end
        chk("noblink_steady", 32'(bad), 32'd0);
        rd(4'h3, d); chk("noblink_status", 32'(d), 32'h1);
`endif

        // Reset mid-period with everything lit and a pending shadow write
        do_reset();
        wr(4'h0, 16'h00FF);
        for (int i = 0; i < NL; i++) wr(4'(8 + i), 16'd255);
        repeat (300) @(negedge clk);
        chk("pre_reset_leds", 32'(user_dataout_0), 32'hFF);
        wr(4'h8, 16'd10);
        rd(4'h0, d); chk("pre_reset_rdata", 32'(d), 32'h00FF);
        reset = 1'b1;
        slave_address = 4'h0; slave_writedata = 16'h000F;
        slave_write = 1'b1; slave_read = 1'b1;
        @(negedge clk);
        chk("reset_leds", 32'(user_dataout_0), 32'h0);
        chk("reset_rdata", 32'(slave_readdata), 32'h0);
        reset = 1'b0; slave_write = 1'b0; slave_read = 1'b0;
        rd(4'h0, d); chk("reset_enable_wins", 32'(d), 32'h0);
        rd(4'h8, d); chk("reset_shadow_dropped", 32'(d), 32'h0);
        rd(4'h3, d); chk("reset_status", 32'(d), 32'h1);
        rd(4'h9, d); chk("reset_duty1", 32'(d), 32'h0);
        acc = '0;
        repeat (300) begin acc |= user_dataout_0; @(negedge clk); end
        chk("reset_leds_stay_off", 32'(acc), 32'h0);

        $display("CHECKS %0d ERRORS %0d", checks, errors);
        $finish;
    end
endmodule
